// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture buffer: records (pc, inst, cycle stamp) per commit,
// fill-once or circular, then drains oldest-first over valid/ready.
module cpu_trace_buffer #(
  parameter int                 DEPTH      = 64,
  parameter int                 PC_W       = 32,
  parameter int                 INST_W     = 32,
  parameter int                 CYC_W      = 16,
  parameter logic [INST_W-1:0]  HALT_INST  = INST_W'(32'hFFFFFFFF),
  parameter int                 MAX_CYCLES = 2048
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     mode,
  input  logic                     stop,
  input  logic                     commit_valid,
  input  logic [PC_W-1:0]          commit_pc,
  input  logic [INST_W-1:0]        commit_inst,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_pc,
  output logic [INST_W-1:0]        rd_inst,
  output logic [CYC_W-1:0]         rd_cycle,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CYC_W-1:0]         cycle_cnt,
  output logic                     wrapped,
  output logic [1:0]               state,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    FULL     = CW'(DEPTH);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CYC_W-1:0]  cycle_q, cycle_d;
  logic              wrapped_q, wrapped_d;
  logic              mode_q, mode_d;
  logic              we;
  logic              stop_hit;
  logic              is_drain;

  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [CYC_W-1:0]  mem_cyc  [DEPTH];

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    cycle_d   = cycle_q;
    wrapped_d = wrapped_q;
    mode_d    = mode_q;
    we        = 1'b0;
    stop_hit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d   = CAPTURE;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          count_d   = '0;
          cycle_d   = '0;
          wrapped_d = 1'b0;
          mode_d    = mode;
        end
      end
      CAPTURE: begin
        if (arm) begin
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          count_d   = '0;
          cycle_d   = '0;
          wrapped_d = 1'b0;
          mode_d    = mode;
        end else begin
          if (cycle_q != '1) cycle_d = cycle_q + CYC_W'(1);
          if (commit_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            // circular overwrite keeps rd_ptr on the oldest entry
            if (mode_q && count_q == FULL) begin
              rd_ptr_d  = rd_ptr_q + AW'(1);
              wrapped_d = 1'b1;
            end else begin
              count_d = count_q + CW'(1);
            end
          end
          stop_hit = stop
                   | (commit_valid && commit_inst == HALT_INST)
                   | ((MAX_CYCLES != 0) && cycle_q == CYC_LAST)
                   | (!mode_q && commit_valid && count_q == FULL - CW'(1));
          if (stop_hit) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == '0) begin
          state_d = IDLE;
        end else if (rd_ready) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cycle_q   <= '0;
      wrapped_q <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cycle_q   <= cycle_d;
      wrapped_q <= wrapped_d;
      mode_q    <= mode_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (we) begin
      mem_pc[wr_ptr_q]   <= commit_pc;
      mem_inst[wr_ptr_q] <= commit_inst;
      mem_cyc[wr_ptr_q]  <= cycle_q;
    end
  end

  assign is_drain  = (state_q == DRAIN);
  assign rd_valid  = is_drain && (count_q != '0);
  assign done      = is_drain && (count_q == '0);
  assign rd_pc     = is_drain ? mem_pc[rd_ptr_q]   : '0;
  assign rd_inst   = is_drain ? mem_inst[rd_ptr_q] : '0;
  assign rd_cycle  = is_drain ? mem_cyc[rd_ptr_q]  : '0;
  assign count     = count_q;
  assign cycle_cnt = cycle_q;
  assign wrapped   = wrapped_q;
  assign state     = state_q;

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Synthesizable commit-trace capture block for the single-cycle CPU. It records (pc, inst, cycle stamp) for each committed instruction into a parametrised buffer, in either fill-once or circular mode. Capture stops on a halt instruction, a cycle limit or an external stop. Entries are then drained oldest-first over a valid/ready port, replacing per-cycle file dumps when running long programs on hardware or in simulation.

Parameters:
DEPTH, 64, number of trace entries; power of two, at least 2
PC_W, 32, pc width
INST_W, 32, instruction width
CYC_W, 16, cycle counter and stamp width
HALT_INST, 32'hFFFFFFFF, instruction encoding that ends capture
MAX_CYCLES, 2048, capture cycle limit; 0 disables the limit

Ports:
clk_in  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
arm  input  1  start a new capture (pulse)
mode  input  1  latched on arm: 0 = fill-once, 1 = circular
stop  input  1  external capture stop
commit_valid  input  1  an instruction commits this cycle
commit_pc  input  PC_W  pc of the committing instruction
commit_inst  input  INST_W  committing instruction word
rd_ready  input  1  sink accepts the current entry
rd_valid  output  1  entry available on rd_*
rd_pc  output  PC_W  entry pc
rd_inst  output  INST_W  entry instruction
rd_cycle  output  CYC_W  entry cycle stamp
count  output  $clog2(DEPTH)+1  entries currently held
cycle_cnt  output  CYC_W  capture cycle counter
wrapped  output  1  circular mode has overwritten at least one entry
state  output  2  0 = IDLE, 1 = CAPTURE, 2 = DRAIN
done  output  1  one-cycle pulse when the drain completes

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; all outputs 0, including rd_valid, count, cycle_cnt, wrapped, done.
  - Write and read pointers and latched mode = 0.
  - Buffer RAM contents are not reset.
- IDLE:
  - arm = 1 at an edge -> CAPTURE. On that edge: pointers, count, cycle_cnt and wrapped are cleared, and mode is latched.
  - commit_valid during IDLE, including the arm cycle, is ignored.
- CAPTURE:
  - cycle_cnt increments every cycle and saturates at all-ones.
  - On commit_valid, the entry {commit_pc, commit_inst, cycle_cnt pre-increment value} is written at wr_ptr, then wr_ptr++ (wrapping modulo DEPTH).
  - First CAPTURE cycle has stamp 0.
- Full handling:
  - Mode 0: count increments; when a write makes count = DEPTH -> DRAIN on that edge.
  - Mode 1 with count = DEPTH: the write overwrites the oldest entry, count stays DEPTH, wrapped is set to 1. rd_ptr tracks wr_ptr, so the oldest entry stays at rd_ptr.
- Stop conditions (OR'd; each transitions to DRAIN on the same edge):
  - stop = 1.
  - commit_valid with commit_inst == HALT_INST.
  - MAX_CYCLES != 0 and cycle_cnt == MAX_CYCLES-1, i.e. exactly MAX_CYCLES capture cycles.
  - Any commit in the stopping cycle is still recorded.
- arm = 1 while in CAPTURE restarts the capture, with the same clears as from IDLE; the commit in that cycle is discarded.
- DRAIN:
  - rd_valid = (count != 0).
  - rd_pc, rd_inst and rd_cycle show the entry at rd_ptr, combinationally from the registered pointer.
  - Transfer occurs on rd_valid & rd_ready: rd_ptr++ (modulo DEPTH), count--.
  - rd_* stay stable while rd_valid & !rd_ready.
  - When count == 0 -> IDLE, with done = 1 for exactly that one cycle. If capture stopped with count = 0, DRAIN lasts one cycle.
  - arm, stop and commit_valid are ignored in DRAIN.
- Read order:
  - Mode 0, or mode 1 not wrapped: starts at entry 0.
  - Mode 1 wrapped: starts at wr_ptr, so the oldest of the last DEPTH commits comes first.
- rd_valid is 0 outside DRAIN; state code 3 is unreachable and recovers to IDLE.

Test Plan:
1. DEPTH=8, mode 0: arm, then 10 back-to-back commits with pc = 0x00400000+4k -> state = DRAIN after 8th, count = 8. Drain yields pc 0x00400000..0x0040001C with stamps 0..7, then done pulses once.
2. DEPTH=8, mode 1: 12 back-to-back commits, then stop -> wrapped = 1, count = 8. Drain yields k = 4..11 in order with stamps 4..11.
3. Mode 0, 5th commit has inst = HALT_INST -> DRAIN immediately, count = 5, last entry inst = 0xFFFFFFFF.
4. MAX_CYCLES=20, commits on even capture cycles -> DRAIN after cycle 19, count = 10, stamps 0,2,...,18.
5. Drain with rd_ready toggling pseudo-randomly -> every entry appears exactly once in order, rd_* stable while stalled, done only after the last accept.
6. Assert reset mid-DRAIN with count = 5 -> rd_valid = 0, count = 0, state = IDLE without a clock edge. A subsequent arm starts a clean capture with stamp 0.
